// File: rtl/counter_pkg.sv
// Shared definitions for the mod-N up/down counter family.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_t;

endpackage

// File: rtl/mod_n_step.sv
// Combinational next-count / terminal-count / direction logic for one enabled step.
module mod_n_step
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] Cout,
    input  logic [WIDTH-1:0] N,
    input  logic             dir,
    input  mode_t            mode,
    output logic [WIDTH-1:0] next,
    output logic             tc_next,
    output logic             dir_next
);

    logic             degenerate;
    logic [WIDTH-1:0] last;
    logic             up_eff;
    logic [WIDTH-1:0] stepped;

    always_comb begin
        degenerate = (N <= WIDTH'(1));
        last       = degenerate ? '0 : N - WIDTH'(1);
        next       = Cout;
        tc_next    = 1'b0;
        dir_next   = dir;
        up_eff     = dir;
        stepped    = Cout;

        if (mode != MODE_HOLD) begin
            if (degenerate) begin
                next    = '0;
                tc_next = 1'b1;
            end else begin
                case (mode)
                    MODE_UP: begin
                        dir_next = 1'b1;
                        if (Cout >= last) begin
                            next    = '0;
                            tc_next = 1'b1;
                        end else begin
                            next = Cout + WIDTH'(1);
                        end
                    end
                    MODE_DOWN: begin
                        dir_next = 1'b0;
                        if ((Cout == '0) || (Cout >= N)) begin
                            next    = last;
                            tc_next = 1'b1;
                        end else begin
                            next = Cout - WIDTH'(1);
                        end
                    end
                    MODE_BOUNCE: begin
                        if (Cout >= N) begin
                            next    = dir ? '0 : last;
                            tc_next = 1'b1;
                        end else begin
                            // Sitting on an endpoint while pointing outward: turn before
                            // stepping so the endpoint is not shown twice.
                            if (dir && (Cout == last)) begin
                                up_eff = 1'b0;
                            end else if (!dir && (Cout == '0)) begin
                                up_eff = 1'b1;
                            end
                            stepped = up_eff ? Cout + WIDTH'(1) : Cout - WIDTH'(1);
                            next    = stepped;
                            if (stepped == last) begin
                                tc_next  = 1'b1;
                                dir_next = 1'b0;
                            end else if (stepped == '0) begin
                                tc_next  = 1'b1;
                                dir_next = 1'b1;
                            end else begin
                                dir_next = up_eff;
                            end
                        end
                    end
                    default: begin
                        next = Cout;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Runtime-modulus up/down/bounce counter with terminal-count pulse and wrap counter.
module mod_n_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned WRAP_W = 8
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  mod_val,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  Cout,
    output logic              tc,
    output logic              dir,
    output logic [WRAP_W-1:0] wrap_cnt
);

    mode_t            mode_sel;
    logic [WIDTH-1:0] step_next;
    logic             step_tc;
    logic             step_dir;
    logic [WIDTH-1:0] load_clamped;

    assign mode_sel = mode_t'(mode);

    mod_n_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .Cout    (Cout),
        .N       (mod_val),
        .dir     (dir),
        .mode    (mode_sel),
        .next    (step_next),
        .tc_next (step_tc),
        .dir_next(step_dir)
    );

    // N of 0 has no valid range, so an out-of-range load falls back to 0 there.
    always_comb begin
        if (load_val < mod_val) begin
            load_clamped = load_val;
        end else if (mod_val == '0) begin
            load_clamped = '0;
        end else begin
            load_clamped = mod_val - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            Cout     <= '0;
            tc       <= 1'b0;
            dir      <= 1'b1;
            wrap_cnt <= '0;
        end else if (load) begin
            Cout <= load_clamped;
            tc   <= 1'b0;
            if (mode_sel == MODE_BOUNCE) begin
                dir <= 1'b1;
            end
        end else if (en) begin
            Cout <= step_next;
            tc   <= step_tc;
            dir  <= step_dir;
            if (step_tc) begin
                wrap_cnt <= wrap_cnt + WRAP_W'(1);
            end
        end else begin
            tc <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Randomized and directed bench for mod_n_updown_counter against an integer reference model.
module tb_mod_n_updown_counter;

    logic       clk = 1'b0;
    logic       clear;
    logic       en;
    logic [1:0] mode;
    logic [3:0] mod_val;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] cout_a;
    logic       tc_a;
    logic       dir_a;
    logic [7:0] wrap_a;
    logic [3:0] cout_b;
    logic       tc_b;
    logic       dir_b;
    logic [1:0] wrap_b;

    int n_checks = 0;
    int n_fail   = 0;

    int m_cnt  = 0;
    int m_dir  = 1;
    int m_tc   = 0;
    int m_wrap = 0;

    always #5 clk = ~clk;

    mod_n_updown_counter u_dut (
        .clk     (clk),
        .clear   (clear),
        .en      (en),
        .mode    (mode),
        .mod_val (mod_val),
        .load    (load),
        .load_val(load_val),
        .Cout    (cout_a),
        .tc      (tc_a),
        .dir     (dir_a),
        .wrap_cnt(wrap_a)
    );

    mod_n_updown_counter #(
        .WIDTH (4),
        .WRAP_W(2)
    ) u_dut_w2 (
        .clk     (clk),
        .clear   (clear),
        .en      (en),
        .mode    (mode),
        .mod_val (mod_val),
        .load    (load),
        .load_val(load_val),
        .Cout    (cout_b),
        .tc      (tc_b),
        .dir     (dir_b),
        .wrap_cnt(wrap_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: behaviour of one rising edge expressed as plain integer rules.
    task automatic model_edge(input int clr, input int ld, input int lv,
                              input int e, input int md, input int n);
        int d;
        if (clr == 0) begin
            m_cnt = 0; m_tc = 0; m_dir = 1; m_wrap = 0;
        end else if (ld != 0) begin
            m_cnt = (lv < n) ? lv : ((n == 0) ? 0 : n - 1);
            m_tc  = 0;
            if (md == 3) m_dir = 1;
        end else if (e != 0) begin
            m_tc = 0;
            if (md == 0) begin
                m_tc = 0;
            end else if (n <= 1) begin
                m_cnt = 0; m_tc = 1;
            end else if (md == 1) begin
                m_dir = 1;
                m_cnt = m_cnt + 1;
                if (m_cnt >= n) begin m_cnt = 0; m_tc = 1; end
            end else if (md == 2) begin
                m_dir = 0;
                if (m_cnt == 0 || m_cnt >= n) begin m_cnt = n - 1; m_tc = 1; end
                else m_cnt = m_cnt - 1;
            end else begin
                if (m_cnt >= n) begin
                    m_cnt = (m_dir != 0) ? 0 : n - 1;
                    m_tc  = 1;
                end else begin
                    d = (m_dir != 0) ? 1 : -1;
                    if (m_cnt + d < 0 || m_cnt + d > n - 1) d = -d;
                    m_cnt = m_cnt + d;
                    if (m_cnt == 0) begin m_tc = 1; m_dir = 1; end
                    else if (m_cnt == n - 1) begin m_tc = 1; m_dir = 0; end
                    else m_dir = (d > 0) ? 1 : 0;
                end
            end
            if (m_tc != 0) m_wrap++;
        end else begin
            m_tc = 0;
        end
    endtask

    task automatic step(input int clr, input int ld, input int lv,
                        input int e, input int md, input int n);
        @(negedge clk);
        clear    = clr[0];
        load     = ld[0];
        load_val = lv[3:0];
        en       = e[0];
        mode     = md[1:0];
        mod_val  = n[3:0];
        @(posedge clk);
        model_edge(clr, ld, lv, e, md, n);
        #1;
        check("cout", int'(cout_a), m_cnt);
        check("tc",   int'(tc_a),   m_tc);
        check("dir",  int'(dir_a),  m_dir);
        check("wrap", int'(wrap_a), m_wrap % 256);
        check("cout_w2", int'(cout_b), m_cnt);
        check("wrap_w2", int'(wrap_b), m_wrap % 4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int e30_c [5]  = '{1, 2, 3, 4, 0};
        int e30_t [5]  = '{0, 0, 0, 0, 1};
        int e31_c [6]  = '{4, 3, 2, 1, 0, 4};
        int e31_t [6]  = '{1, 0, 0, 0, 0, 1};
        int e32_c [7]  = '{1, 2, 3, 2, 1, 0, 1};
        int e32_t [7]  = '{0, 0, 1, 0, 0, 1, 0};
        int e32_d [7]  = '{1, 1, 0, 0, 0, 1, 1};
        int e35_w [9]  = '{0, 1, 1, 2, 2, 3, 3, 0, 0};
        int n_cur;

        clear = 1'b0; en = 1'b0; load = 1'b0; mode = 2'b00;
        mod_val = 4'd5; load_val = 4'd0;

        // Reset state, with load/en active to confirm clear dominates.
        step(0, 1, 9, 1, 1, 5);
        check("rst_cout", int'(cout_a), 0);
        check("rst_dir",  int'(dir_a),  1);
        check("rst_tc",   int'(tc_a),   0);

        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 1, 1, 5);
            check("up_seq", int'(cout_a), e30_c[i]);
            check("up_tc",  int'(tc_a),   e30_t[i]);
        end
        check("up_wrap", int'(wrap_a), 1);

        step(0, 0, 0, 0, 0, 5);
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0, 1, 2, 5);
            check("dn_seq", int'(cout_a), e31_c[i]);
            check("dn_tc",  int'(tc_a),   e31_t[i]);
            check("dn_dir", int'(dir_a),  0);
        end

        step(0, 0, 0, 0, 0, 4);
        for (int i = 0; i < 7; i++) begin
            step(1, 0, 0, 1, 3, 4);
            check("bn_seq", int'(cout_a), e32_c[i]);
            check("bn_tc",  int'(tc_a),   e32_t[i]);
            check("bn_dir", int'(dir_a),  e32_d[i]);
        end

        // Lower modulus under a count that is now out of range, then clamp a load.
        step(0, 0, 0, 0, 0, 10);
        step(1, 1, 7, 0, 1, 10);
        check("ld7", int'(cout_a), 7);
        step(1, 0, 0, 1, 1, 5);
        check("shrink_cout", int'(cout_a), 0);
        check("shrink_tc",   int'(tc_a),   1);
        step(1, 1, 9, 0, 1, 5);
        check("clamp_cout", int'(cout_a), 4);
        check("clamp_tc",   int'(tc_a),   0);

        // Clear alongside load and en mid-count.
        step(0, 0, 0, 0, 0, 5);
        step(1, 0, 0, 1, 2, 5);
        step(1, 0, 0, 1, 2, 5);
        check("pre_clr", int'(cout_a), 3);
        step(0, 1, 2, 1, 2, 5);
        check("clr_cout", int'(cout_a), 0);
        check("clr_wrap", int'(wrap_a), 0);
        check("clr_dir",  int'(dir_a),  1);

        step(0, 0, 0, 0, 0, 2);
        for (int i = 0; i < 9; i++) begin
            step(1, 0, 0, 1, 1, 2);
            check("w2_seq", int'(wrap_b), e35_w[i]);
        end
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 1, 1, 1);
            check("n1_tc",   int'(tc_a),   1);
            check("n1_cout", int'(cout_a), 0);
        end

        n_cur = 6;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) n_cur = $urandom_range(0, 15);
            step(($urandom_range(0, 39) == 0) ? 0 : 1,
                 ($urandom_range(0, 11) == 0) ? 1 : 0,
                 $urandom_range(0, 15),
                 ($urandom_range(0, 3) == 0) ? 0 : 1,
                 $urandom_range(0, 3),
                 n_cur);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/mod_n_updown_counter.md
MOD_N_UPDOWN_COUNTER -- requirements
Module: mod_n_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, count/modulus width in bits (legal 2..16).
REQ-002 SHALL have parameter WRAP_W, default 8, wrap-event counter width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port clear, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port en, input, 1, count enable; the counter advances one step per cycle while high.
REQ-006 SHALL have port mode, input, 2, direction mode: 00 hold, 01 up, 10 down, 11 bounce.
REQ-007 SHALL have port mod_val, input, WIDTH, runtime modulus N; the count range is 0..N-1.
REQ-008 SHALL have port load, input, 1, synchronous load strobe.
REQ-009 SHALL have port load_val, input, WIDTH, value applied on load.
REQ-010 SHALL have port Cout, output, WIDTH, registered count.
REQ-011 SHALL have port tc, output, 1, registered terminal-count pulse.
REQ-012 SHALL have port dir, output, 1, current direction (1 = up).
REQ-013 SHALL have port wrap_cnt, output, WRAP_W, registered count of tc pulses, modulo 2^WRAP_W.

Function
REQ-014 Priority SHALL be clear > load > en; with en low and load low, all state SHALL hold.
REQ-015 Up mode SHALL step Cout+1 and SHALL wrap from N-1 to 0, with tc=1 in the cycle Cout shows 0.
REQ-016 Down mode SHALL step Cout-1 and SHALL wrap from 0 to N-1, with tc=1 in the cycle Cout shows N-1.
REQ-017 Bounce mode SHALL count up to N-1 and then down to 0, repeating; the turn values SHALL NOT repeat; tc=1 in the cycle Cout reaches either endpoint.
REQ-018 dir SHALL be 1 in up mode and 0 in down mode; in bounce mode it SHALL toggle on the cycle an endpoint is reached. Hold mode SHALL freeze Cout and dir even with en high.
REQ-019 tc SHALL be a single-cycle pulse registered with Cout (zero latency relative to Cout); wrap_cnt SHALL increment in the same cycle as tc and SHALL roll over silently.
REQ-020 Load SHALL set Cout = load_val if load_val < N, else N-1. Load SHALL NOT assert tc. Load SHALL set dir=1 in bounce mode.
REQ-021 If Cout >= N on an enabled step (mod_val lowered at runtime): up/bounce-up SHALL go to 0, and down/bounce-down SHALL go to N-1; tc SHALL assert.
REQ-022 N = 0 or N = 1: Cout SHALL stay 0, dir SHALL hold, and tc SHALL pulse on every enabled non-hold cycle.
REQ-023 A mode change SHALL take effect on the next enabled edge. Entering bounce mode SHALL keep the current dir.
REQ-024 The next-state computation SHALL be width-safe: no carry or borrow outside WIDTH bits, and N-1 is evaluated only for N >= 1.

Reset
REQ-025 With clear=0 at a rising edge: Cout=0, tc=0, dir=1, wrap_cnt=0, regardless of load/en/mode.
REQ-026 Reset asserted mid-count SHALL take effect on that edge. The first step after release SHALL start from 0.
REQ-027 No initial blocks SHALL be used for functional state; clear is the only initialisation mechanism.

Structure
REQ-028 The mode encodings (MODE_HOLD, MODE_UP, MODE_DOWN, MODE_BOUNCE) SHALL reside in shared package counter_pkg.
REQ-029 The next-value/terminal logic SHALL be one combinational sub-module, mod_n_step (inputs: Cout, N, dir, mode; outputs: next, tc_next, dir_next). All registers SHALL reside in the top.

Verification
REQ-030 WIDTH=4, N=5, mode=01, en=1 after clear: Cout 0,1,2,3,4,0. tc=1 only at the second 0. wrap_cnt=1.
REQ-031 N=5, mode=10 after clear: Cout 4,3,2,1,0,4. tc at the first 4 and at the 0->4 wrap. dir=0.
REQ-032 N=4, mode=11 after clear: Cout 1,2,3,2,1,0,1. tc at 3 and at 0. dir falls at 3 and rises at 0.
REQ-033 Cout=7, N=10, then mod_val set to 5 with mode=01: next Cout=0 with tc=1. Then load=1 with load_val=9: Cout=4 and tc=0.
REQ-034 clear=0 asserted together with load=1 and en=1 at Cout=3: Cout=0, wrap_cnt=0, and dir=1 the next cycle.
REQ-035 WRAP_W=2, N=2, mode=01 for 9 enabled cycles: wrap_cnt sequence 0,1,1,2,2,3,3,0,0. With N=1, tc SHALL be high every enabled cycle.
